// File: rtl/switch_ctrl_pkg.sv
// Shared register map and reset defaults for the switch-bank AHB-Lite controller.
// Offsets are word indices, which are the values of HADDR[4:2].
package switch_ctrl_pkg;

  localparam logic [2:0] OFS_DATA    = 3'd0;
  localparam logic [2:0] OFS_RAW     = 3'd1;
  localparam logic [2:0] OFS_STATUS  = 3'd2;
  localparam logic [2:0] OFS_MASK    = 3'd3;
  localparam logic [2:0] OFS_RISE_EN = 3'd4;
  localparam logic [2:0] OFS_FALL_EN = 3'd5;
  localparam logic [2:0] OFS_PERIOD  = 3'd6;
  localparam logic [2:0] OFS_SAMPLES = 3'd7;

  localparam int unsigned RST_PERIOD  = 1000;
  localparam int unsigned RST_SAMPLES = 3;
  localparam int          SAMPLES_W   = 4;

  // A programmed SAMPLES of 0 is treated as 1 so a change is still accepted.
  function automatic logic [SAMPLES_W-1:0] eff_samples(input logic [SAMPLES_W-1:0] s);
    return (s == '0) ? SAMPLES_W'(1) : s;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch channel: 2-FF synchroniser, tick-driven stability counter,
// debounced level and single-cycle rise/fall pulses aligned with the level update.
module switch_debounce_bit
  import switch_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sw_i,
  input  logic                 tick_i,
  input  logic [SAMPLES_W-1:0] samples_i,
  output logic                 sync_o,
  output logic                 data_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  logic                 meta_q, sync_q;
  logic                 data_q, data_d;
  logic [SAMPLES_W-1:0] cnt_q, cnt_d;
  logic                 accept;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q;
    data_d = data_q;
    accept = 1'b0;
    if (tick_i) begin
      if (sync_q == data_q) begin
        cnt_d = '0;
      end else if (cnt_q + SAMPLES_W'(1) >= samples_i) begin
        accept = 1'b1;
        data_d = sync_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + SAMPLES_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      data_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= sw_i;
      sync_q <= meta_q;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync_o = sync_q;
  assign data_o = data_q;
  assign rise_o = accept & sync_q;
  assign fall_o = accept & ~sync_q;

endmodule

// File: rtl/switch_debounce_ctrl.sv
// AHB-Lite slave for the board switch bank: prescaler, per-bit debouncers,
// W1C edge status, masked level interrupt. Zero wait states.
module switch_debounce_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int          NSW         = 15,
  parameter int          PRE_W       = 16,
  parameter int unsigned DEF_PERIOD  = RST_PERIOD,
  parameter int unsigned DEF_SAMPLES = RST_SAMPLES
) (
  input  logic           HCLK,
  input  logic           HRESET,
  input  logic           HSEL,
  input  logic [31:0]    HADDR,
  input  logic [1:0]     HTRANS,
  input  logic           HWRITE,
  input  logic           HREADY,
  input  logic [31:0]    HWDATA,
  output logic           HREADYOUT,
  output logic [31:0]    HRDATA,
  output logic           SWITCH_IRQ,
  input  logic [NSW-1:0] SWITCH
);

  localparam logic [PRE_W-1:0]     PERIOD_RST  = PRE_W'(DEF_PERIOD);
  localparam logic [SAMPLES_W-1:0] SAMPLES_RST = SAMPLES_W'(DEF_SAMPLES);

  logic [NSW-1:0]       data_vec, raw_vec, rise_vec, fall_vec, set_vec;
  logic [NSW-1:0]       status_q, status_d, mask_q, rise_en_q, fall_en_q;
  logic [PRE_W-1:0]     period_q, pre_q, pre_d, period_m1;
  logic [SAMPLES_W-1:0] samples_q;
  logic [31:0]          hrdata_q, rdata_d;
  logic                 irq_q, wr_q, acc, wr_en, tick;
  logic [2:0]           addr_q;
  logic                 unused_bits;

  assign acc   = HSEL & HREADY & HTRANS[1];
  assign wr_en = wr_q & HREADY;

  // PERIOD==0 collapses to a tick every cycle, same as PERIOD==1.
  assign period_m1 = (period_q == '0) ? '0 : period_q - PRE_W'(1);
  assign tick      = (pre_q == period_m1);

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    if ((wr_en && addr_q == OFS_PERIOD) || tick) pre_d = '0;
  end

  for (genvar g = 0; g < NSW; g++) begin : g_bit
    switch_debounce_bit u_bit (
      .clk_i     (HCLK),
      .rst_i     (HRESET),
      .sw_i      (SWITCH[g]),
      .tick_i    (tick),
      .samples_i (eff_samples(samples_q)),
      .sync_o    (raw_vec[g]),
      .data_o    (data_vec[g]),
      .rise_o    (rise_vec[g]),
      .fall_o    (fall_vec[g])
    );
  end

  // A new edge in the same cycle as a W1C keeps the bit set.
  assign set_vec = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);

  always_comb begin
    status_d = status_q;
    if (wr_en && addr_q == OFS_STATUS) status_d = status_q & ~HWDATA[NSW-1:0];
    status_d = status_d | set_vec;
  end

  always_comb begin
    rdata_d = '0;
    case (HADDR[4:2])
      OFS_DATA:    rdata_d[NSW-1:0]       = data_vec;
      OFS_RAW:     rdata_d[NSW-1:0]       = raw_vec;
      OFS_STATUS:  rdata_d[NSW-1:0]       = status_q;
      OFS_MASK:    rdata_d[NSW-1:0]       = mask_q;
      OFS_RISE_EN: rdata_d[NSW-1:0]       = rise_en_q;
      OFS_FALL_EN: rdata_d[NSW-1:0]       = fall_en_q;
      OFS_PERIOD:  rdata_d[PRE_W-1:0]     = period_q;
      default:     rdata_d[SAMPLES_W-1:0] = samples_q;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_q      <= 1'b0;
      addr_q    <= '0;
      hrdata_q  <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      period_q  <= PERIOD_RST;
      samples_q <= SAMPLES_RST;
      pre_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (HREADY) begin
        wr_q   <= acc & HWRITE;
        addr_q <= HADDR[4:2];
      end
      if (acc && !HWRITE) hrdata_q <= rdata_d;
      if (wr_en) begin
        case (addr_q)
          OFS_MASK:    mask_q    <= HWDATA[NSW-1:0];
          OFS_RISE_EN: rise_en_q <= HWDATA[NSW-1:0];
          OFS_FALL_EN: fall_en_q <= HWDATA[NSW-1:0];
          OFS_PERIOD:  period_q  <= HWDATA[PRE_W-1:0];
          OFS_SAMPLES: samples_q <= HWDATA[SAMPLES_W-1:0];
          default: ;
        endcase
      end
      status_q <= status_d;
      pre_q    <= pre_d;
      irq_q    <= |(status_q & mask_q);
    end
  end

  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  assign HREADYOUT  = 1'b1;
  assign HRDATA     = hrdata_q;
  assign SWITCH_IRQ = irq_q;

endmodule
